// File: rtl/pong_motion_engine_if.sv
// Game-state bundle between the motion engine and the pixel colour stage:
// frame timing and paddle buttons in, bounding boxes and point pulses out.
interface pong_motion_engine_if;
    logic       VBlank;
    logic       BtnLUp;
    logic       BtnLDn;
    logic       BtnRUp;
    logic       BtnRDn;
    logic [9:0] LHmin, LHmax, LVmin, LVmax;
    logic [9:0] RHmin, RHmax, RVmin, RVmax;
    logic [9:0] BHmin, BHmax, BVmin, BVmax;
    logic       scoreL;
    logic       scoreR;

    modport master (
        input  VBlank, BtnLUp, BtnLDn, BtnRUp, BtnRDn,
        output LHmin, LHmax, LVmin, LVmax,
        output RHmin, RHmax, RVmin, RVmax,
        output BHmin, BHmax, BVmin, BVmax,
        output scoreL, scoreR
    );

    modport slave (
        output VBlank, BtnLUp, BtnLDn, BtnRUp, BtnRDn,
        input  LHmin, LHmax, LVmin, LVmax,
        input  RHmin, RHmax, RVmin, RVmax,
        input  BHmin, BHmax, BVmin, BVmax,
        input  scoreL, scoreR
    );
endinterface

// File: rtl/pong_motion_engine.sv
// Pong motion engine: paddles, ball, bounces, misses and serve delay.
// Every object advances once per frame, on the rising edge of VBlank.
module pong_motion_engine #(
    parameter logic [9:0]  BORDER_L     = 10'd10,
    parameter logic [9:0]  BORDER_R     = 10'd790,
    parameter logic [9:0]  BORDER_T     = 10'd10,
    parameter logic [9:0]  BORDER_B     = 10'd590,
    parameter logic [9:0]  LPAD_X       = 10'd30,
    parameter logic [9:0]  RPAD_X       = 10'd760,
    parameter logic [9:0]  PADDLE_W     = 10'd10,
    parameter logic [9:0]  PADDLE_H     = 10'd80,
    parameter logic [9:0]  BALL_SZ      = 10'd10,
    parameter logic [9:0]  PADDLE_STEP  = 10'd4,
    parameter logic [9:0]  BALL_STEP    = 10'd2,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input logic                  CLK_100MHz,
    input logic                  Reset,
    pong_motion_engine_if.master bus
);
    // state     | meaning
    // ST_SERVE  | ball parked at centre while the serve delay counts down
    // ST_PLAY   | ball moving; bounces and misses evaluated every frame
    // ST_SCORED | one clock after a miss: drop pulse, recentre, reload delay
    localparam logic [1:0] ST_SERVE  = 2'd0;
    localparam logic [1:0] ST_PLAY   = 2'd1;
    localparam logic [1:0] ST_SCORED = 2'd2;

    localparam int         CNT_W   = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0] BALL_H0 = 10'((32'(BORDER_L) + 32'(BORDER_R) - 32'(BALL_SZ)) / 2);
    localparam logic [9:0] BALL_V0 = 10'((32'(BORDER_T) + 32'(BORDER_B) - 32'(BALL_SZ)) / 2);
    localparam logic [9:0] PAD_V0  = 10'((32'(BORDER_T) + 32'(BORDER_B) - 32'(PADDLE_H)) / 2);
    localparam logic [9:0] LPAD_XR = LPAD_X + PADDLE_W;

    logic [1:0]       state;
    logic [CNT_W-1:0] serve_cnt;
    logic             vb_q;
    logic             tick;
    logic [9:0]       lv_min, rv_min, bh_min, bv_min;
    logic [9:0]       lv_max, rv_max, bh_max, bv_max;
    logic             dx;  // 1 = right
    logic             dy;  // 1 = down
    logic             score_l, score_r;
    logic [9:0]       bv_nxt;
    logic             dy_nxt;
    logic             l_hit, r_hit, l_miss, r_miss;

    function automatic logic [9:0] paddle_next(input logic [9:0] cur, input logic up,
                                               input logic dn);
        paddle_next = cur;
        if (up && !dn)
            paddle_next = (cur >= BORDER_T + PADDLE_STEP) ? cur - PADDLE_STEP : BORDER_T;
        else if (dn && !up)
            paddle_next = (cur + PADDLE_H + PADDLE_STEP <= BORDER_B) ? cur + PADDLE_STEP
                                                                      : BORDER_B - PADDLE_H;
    endfunction

    assign tick   = bus.VBlank & ~vb_q;
    assign lv_max = lv_min + PADDLE_H;
    assign rv_max = rv_min + PADDLE_H;
    assign bh_max = bh_min + BALL_SZ;
    assign bv_max = bv_min + BALL_SZ;

    // Bounds are formed on the right-hand side so nothing subtracts below zero.
    assign l_hit  = !dx && (bh_min >= LPAD_XR) && (bh_min <= LPAD_XR + BALL_STEP)
                    && (bv_max >= lv_min) && (bv_min <= lv_max);
    assign r_hit  = dx && (bh_max <= RPAD_X) && (bh_max + BALL_STEP >= RPAD_X)
                    && (bv_max >= rv_min) && (bv_min <= rv_max);
    assign l_miss = !dx && !l_hit && (bh_min <= BORDER_L + BALL_STEP);
    assign r_miss = dx && !r_hit && (bh_max + BALL_STEP >= BORDER_R);

    always_comb begin
        bv_nxt = bv_min;
        dy_nxt = dy;
        if (!dy && (bv_min < BORDER_T + BALL_STEP)) begin
            bv_nxt = BORDER_T;
            dy_nxt = 1'b1;
        end else if (dy && (bv_max + BALL_STEP > BORDER_B)) begin
            bv_nxt = BORDER_B - BALL_SZ;
            dy_nxt = 1'b0;
        end else if (dy) begin
            bv_nxt = bv_min + BALL_STEP;
        end else begin
            bv_nxt = bv_min - BALL_STEP;
        end
    end

    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) begin
            // vb_q starts high so a VBlank already asserted at release is not a frame tick
            vb_q      <= 1'b1;
            state     <= ST_SERVE;
            serve_cnt <= CNT_W'(SERVE_FRAMES);
            lv_min    <= PAD_V0;
            rv_min    <= PAD_V0;
            bh_min    <= BALL_H0;
            bv_min    <= BALL_V0;
            dx        <= 1'b1;
            dy        <= 1'b1;
            score_l   <= 1'b0;
            score_r   <= 1'b0;
        end else begin
            vb_q    <= bus.VBlank;
            score_l <= 1'b0;
            score_r <= 1'b0;
            if (tick) begin
                lv_min <= paddle_next(lv_min, bus.BtnLUp, bus.BtnLDn);
                rv_min <= paddle_next(rv_min, bus.BtnRUp, bus.BtnRDn);
            end
            case (state)
                ST_SERVE: begin
                    if (tick) begin
                        serve_cnt <= serve_cnt - CNT_W'(1);
                        if (serve_cnt == CNT_W'(1))
                            state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        bv_min <= bv_nxt;
                        dy     <= dy_nxt;
                        if (l_hit) begin
                            bh_min <= LPAD_XR;
                            dx     <= 1'b1;
                        end else if (r_hit) begin
                            bh_min <= RPAD_X - BALL_SZ;
                            dx     <= 1'b0;
                        end else if (l_miss) begin
                            score_r <= 1'b1;
                            state   <= ST_SCORED;
                        end else if (r_miss) begin
                            score_l <= 1'b1;
                            state   <= ST_SCORED;
                        end else if (dx) begin
                            bh_min <= bh_min + BALL_STEP;
                        end else begin
                            bh_min <= bh_min - BALL_STEP;
                        end
                    end
                end
                ST_SCORED: begin
                    // serve toward the player who just lost the point
                    bh_min    <= BALL_H0;
                    bv_min    <= BALL_V0;
                    serve_cnt <= CNT_W'(SERVE_FRAMES);
                    dx        <= ~score_r;
                    state     <= ST_SERVE;
                end
                default: state <= ST_SERVE;
            endcase
        end
    end

    assign bus.LHmin  = LPAD_X;
    assign bus.LHmax  = LPAD_XR;
    assign bus.LVmin  = lv_min;
    assign bus.LVmax  = lv_max;
    assign bus.RHmin  = RPAD_X;
    assign bus.RHmax  = RPAD_X + PADDLE_W;
    assign bus.RVmin  = rv_min;
    assign bus.RVmax  = rv_max;
    assign bus.BHmin  = bh_min;
    assign bus.BHmax  = bh_max;
    assign bus.BVmin  = bv_min;
    assign bus.BVmax  = bv_max;
    assign bus.scoreL = score_l;
    assign bus.scoreR = score_r;
endmodule

// File: tb/tb_pong_motion_engine.sv
// Directed bench for pong_motion_engine: a table of {frames, buttons, expected boxes}
// rows along a hand-traced ball path, plus hand sequences for score pulses and reset.
module tb_pong_motion_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pong_motion_engine_if bus ();

    pong_motion_engine dut (
        .CLK_100MHz(clk),
        .Reset     (rst_n),
        .bus       (bus)
    );

    typedef struct {
        int         seg;
        int         frames;
        logic [3:0] btn;   // {LUp, LDn, RUp, RDn}
        int         lv;
        int         rv;
        int         bh;
        int         bv;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(input int seg, input int frames, input logic [3:0] btn,
                                input int lv, input int rv, input int bh, input int bv);
        vec_t v;
        v.seg = seg; v.frames = frames; v.btn = btn;
        v.lv = lv; v.rv = rv; v.bh = bh; v.bv = bv;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic frame();
        @(negedge clk) bus.VBlank = 1'b1;
        @(negedge clk);
        @(negedge clk) bus.VBlank = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_row(input int i);
        @(negedge clk);
        {bus.BtnLUp, bus.BtnLDn, bus.BtnRUp, bus.BtnRDn} = vecs[i].btn;
        repeat (vecs[i].frames) frame();
        check($sformatf("row%0d_lhmin", i), bus.LHmin, 30);
        check($sformatf("row%0d_lhmax", i), bus.LHmax, 40);
        check($sformatf("row%0d_lvmin", i), bus.LVmin, vecs[i].lv);
        check($sformatf("row%0d_lvmax", i), bus.LVmax, vecs[i].lv + 80);
        check($sformatf("row%0d_rhmin", i), bus.RHmin, 760);
        check($sformatf("row%0d_rhmax", i), bus.RHmax, 770);
        check($sformatf("row%0d_rvmin", i), bus.RVmin, vecs[i].rv);
        check($sformatf("row%0d_rvmax", i), bus.RVmax, vecs[i].rv + 80);
        check($sformatf("row%0d_bhmin", i), bus.BHmin, vecs[i].bh);
        check($sformatf("row%0d_bhmax", i), bus.BHmax, vecs[i].bh + 10);
        check($sformatf("row%0d_bvmin", i), bus.BVmin, vecs[i].bv);
        check($sformatf("row%0d_bvmax", i), bus.BVmax, vecs[i].bv + 10);
        check($sformatf("row%0d_scorel", i), bus.scoreL, 0);
        check($sformatf("row%0d_scorer", i), bus.scoreR, 0);
    endtask

    task automatic run_seg(input int seg);
        foreach (vecs[i])
            if (vecs[i].seg == seg) apply_row(i);
    endtask

    // Scoring frame: pulse visible right after the tick, gone one clock later with ball recentred.
    task automatic score_frame(input logic exp_l, input logic exp_r);
        @(negedge clk) bus.VBlank = 1'b1;
        @(posedge clk); #1;
        check("pulse_scorel", bus.scoreL, exp_l);
        check("pulse_scorer", bus.scoreR, exp_r);
        @(posedge clk); #1;
        check("after_pulse_scorel", bus.scoreL, 0);
        check("after_pulse_scorer", bus.scoreR, 0);
        check("recentre_bhmin", bus.BHmin, 395);
        check("recentre_bvmin", bus.BVmin, 295);
        @(negedge clk) bus.VBlank = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.VBlank = 1'b0;
        {bus.BtnLUp, bus.BtnLDn, bus.BtnRUp, bus.BtnRDn} = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.VBlank = 1'b0;
        {bus.BtnLUp, bus.BtnLDn, bus.BtnRUp, bus.BtnRDn} = 4'b0000;

        // run 1: serve, right miss, top bounce, right hit, left hit
        add(0,   0, 4'b0000, 260, 260, 395, 295);
        add(0,   5, 4'b1111, 260, 260, 395, 295);
        add(0,  54, 4'b0000, 260, 260, 395, 295);
        add(0,   1, 4'b0000, 260, 260, 395, 295);
        add(0,   1, 4'b0000, 260, 260, 397, 297);
        add(0, 141, 4'b0000, 260, 260, 679, 579);
        add(0,   1, 4'b0000, 260, 260, 681, 580);
        add(0,   1, 4'b0000, 260, 260, 683, 578);
        add(0,  48, 4'b0000, 260, 260, 779, 482);
        add(1,  62, 4'b0010, 260,  12, 399, 291);
        add(1,   1, 4'b0010, 260,  10, 401, 289);
        add(1,   2, 4'b0010, 260,  10, 405, 285);
        add(1, 137, 4'b0000, 260,  10, 679,  11);
        add(1,   1, 4'b0000, 260,  10, 681,  10);
        add(1,   1, 4'b0000, 260,  10, 683,  12);
        add(1,  33, 4'b0000, 260,  10, 749,  78);
        add(1,   1, 4'b0000, 260,  10, 750,  80);
        add(1,   9, 4'b0100, 296,  10, 732,  98);
        add(1, 241, 4'b0000, 296,  10, 250, 580);
        add(1,   1, 4'b0000, 296,  10, 248, 580);
        add(1,   1, 4'b0000, 296,  10, 246, 578);
        add(1, 102, 4'b0000, 296,  10,  42, 374);
        add(1,   1, 4'b0000, 296,  10,  40, 372);
        add(1,   1, 4'b0000, 296,  10,  42, 370);
        // run 2: left paddle clamps at the top wall, ball later misses on the left
        add(2,   0, 4'b0000, 260, 260, 395, 295);
        add(2,  62, 4'b1000,  12, 260, 399, 299);
        add(2,   1, 4'b1000,  10, 260, 401, 301);
        add(2,   2, 4'b1000,  10, 260, 405, 305);
        add(2, 187, 4'b0000,  10, 260, 779, 482);
        add(3,  65, 4'b0010,  10,  10, 405, 285);
        add(3, 173, 4'b0000,  10,  10, 750,  80);
        add(3, 369, 4'b0000,  10,  10,  12, 344);
        add(4,  59, 4'b0000,  10,  10, 395, 295);
        add(4,   1, 4'b0000,  10,  10, 395, 295);
        add(4,   1, 4'b0000,  10,  10, 393, 293);
        // run 3: reset during a score pulse, then a full serve
        add(5, 252, 4'b0000, 260, 260, 779, 482);
        add(6,  59, 4'b0000, 260, 260, 395, 295);
        add(6,   1, 4'b0000, 260, 260, 395, 295);
        add(6,   1, 4'b0000, 260, 260, 397, 297);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_seg(0);
        score_frame(1'b1, 1'b0);
        run_seg(1);

        do_reset();
        run_seg(2);
        score_frame(1'b1, 1'b0);
        run_seg(3);
        score_frame(1'b0, 1'b1);
        run_seg(4);

        do_reset();
        run_seg(5);
        @(negedge clk) bus.VBlank = 1'b1;
        @(posedge clk); #1;
        check("rst_pulse_scorel_high", bus.scoreL, 1);
        rst_n = 1'b0;
        #1;
        check("rst_pulse_scorel_drop", bus.scoreL, 0);
        check("rst_pulse_scorer", bus.scoreR, 0);
        check("rst_pulse_bhmin", bus.BHmin, 395);
        check("rst_pulse_bvmin", bus.BVmin, 295);
        check("rst_pulse_lvmin", bus.LVmin, 260);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("release_vblank_high_bhmin", bus.BHmin, 395);
        check("release_vblank_high_scorel", bus.scoreL, 0);
        bus.VBlank = 1'b0;
        @(negedge clk);
        run_seg(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
